// File: rtl/isqrt_shared_arbiter.sv
// Shares one in-order multi-cycle isqrt unit among N_REQ requesters with round-robin grant,
// a tag FIFO for result routing and a credit limit. Define ISQRT_ARB_FIXED_PRIO_EN for fixed priority.
module isqrt_shared_arbiter #(
  parameter int N_REQ        = 4,
  parameter int W            = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  output logic [N_REQ-1:0]     req_rdy,
  input  logic [N_REQ*W-1:0]   req_x,
  output logic [N_REQ-1:0]     resp_vld,
  output logic [W-1:0]         resp_y,
  output logic                 sqrt_x_vld,
  output logic [W-1:0]         sqrt_x,
  input  logic                 sqrt_y_vld,
  input  logic [W-1:0]         sqrt_y,
  output logic                 err
);

  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0] inflight;
  logic [TW-1:0] tag_mem [MAX_INFLIGHT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop;
  logic          found;
  logic [TW-1:0] grant_idx;
  logic [W-1:0]  grant_x;
  logic [TW-1:0] head_tag;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (inflight == CW'(MAX_INFLIGHT));
  assign empty    = (inflight == '0);
  assign accept   = |(req_vld & req_rdy);
  assign pop      = sqrt_y_vld && !empty;
  assign head_tag = tag_mem[rd_ptr];
  assign grant_x  = req_x[grant_idx*W +: W];

  // Handshake: a request transfers in the cycle where req_vld[i] && req_rdy[i]. req_rdy is
  // one-hot or zero and is derived only from req_vld, the grant pointer and the credit count,
  // so a pop in the same cycle never frees a slot early. Responses carry no ready.
`ifdef ISQRT_ARB_FIXED_PRIO_EN
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    req_rdy   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_vld[k]) begin
        found     = 1'b1;
        grant_idx = TW'(k);
      end
    end
    if (found && !full) req_rdy[grant_idx] = 1'b1;
  end
`else
  logic [TW-1:0] rr_ptr;
  int            cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    req_rdy   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_vld[TW'(cand)]) begin
        found     = 1'b1;
        grant_idx = TW'(cand);
      end
    end
    if (found && !full) req_rdy[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= TW'(N_REQ - 1);
    else if (accept) rr_ptr <= grant_idx;
  end
`endif

  // Tag storage needs no reset: occupancy is tracked by inflight and the pointers.
  always_ff @(posedge clk) begin
    if (!rst && accept) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sqrt_x_vld <= 1'b0;
      sqrt_x     <= '0;
      resp_vld   <= '0;
      resp_y     <= '0;
      err        <= 1'b0;
    end else begin
      sqrt_x_vld <= accept;
      if (accept) begin
        sqrt_x <= grant_x;
        wr_ptr <= ptr_next(wr_ptr);
      end
      resp_vld <= pop ? (N_REQ'(1) << head_tag) : '0;
      if (pop) begin
        resp_y <= sqrt_y;
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (sqrt_y_vld && empty) err <= 1'b1;
      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Bench for isqrt_shared_arbiter with a 4-stage behavioural isqrt and per-requester expected queues.
module tb_isqrt_shared_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_vld;
  logic [3:0]   req_rdy;
  logic [127:0] req_x;
  logic [3:0]   resp_vld;
  logic [31:0]  resp_y;
  logic         sqrt_x_vld;
  logic [31:0]  sqrt_x;
  logic         sqrt_y_vld;
  logic [31:0]  sqrt_y;
  logic         err;
  logic         inj_vld;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [4][$];

  always #5 clk = ~clk;

  isqrt_shared_arbiter #(.N_REQ(4), .W(32), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x),
    .resp_vld(resp_vld), .resp_y(resp_y), .sqrt_x_vld(sqrt_x_vld), .sqrt_x(sqrt_x),
    .sqrt_y_vld(sqrt_y_vld), .sqrt_y(sqrt_y), .err(err)
  );

  function automatic logic [31:0] isqrt_ref(input logic [31:0] x);
    logic [63:0] y;
    logic [63:0] t;
    y = 0;
    for (int b = 15; b >= 0; b--) begin
      t = y | (64'd1 << b);
      if (t * t <= {32'd0, x}) y = t;
    end
    return y[31:0];
  endfunction

  // Behavioural isqrt, latency 4, in order, shares rst.
  logic [3:0]  pv;
  logic [31:0] py [4];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[2:0], sqrt_x_vld};
    py[0] <= isqrt_ref(sqrt_x);
    py[1] <= py[0];
    py[2] <= py[1];
    py[3] <= py[2];
  end
  assign sqrt_y_vld = pv[3] | inj_vld;
  assign sqrt_y     = inj_vld ? 32'd77 : py[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on each response.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      chk("rdy_onehot0", $onehot0(req_rdy), 1);
      for (int i = 0; i < 4; i++)
        if (req_vld[i] && req_rdy[i]) exp_q[i].push_back(isqrt_ref(req_x[i*32 +: 32]));
      if (resp_vld != 0) begin
        chk("resp_onehot", $onehot(resp_vld), 1);
        for (int i = 0; i < 4; i++) begin
          if (resp_vld[i]) begin
            chk("resp_expected", exp_q[i].size() != 0, 1);
            if (exp_q[i].size() != 0) chk("sb_y", resp_y, exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_vld = '0;
    repeat (n) cyc();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_resp_vld"}, resp_vld, 0);
    chk({tag, "_resp_y"}, resp_y, 0);
    chk({tag, "_sqrt_x_vld"}, sqrt_x_vld, 0);
    chk({tag, "_sqrt_x"}, sqrt_x, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_req_rdy"}, req_rdy, 0);
  endtask

  // Called just after a posedge; leaves just after a posedge.
  task automatic single(input int r, input logic [31:0] x, input logic [31:0] y);
    int n;
    req_vld = 4'b0001 << r;
    req_x = '0;
    req_x[r*32 +: 32] = x;
    @(negedge clk);
    chk("single_rdy", req_rdy, 4'b0001 << r);
    cyc();
    req_vld = '0;
    @(negedge clk);
    chk("single_sqrt_x_vld", sqrt_x_vld, 1);
    chk("single_sqrt_x", sqrt_x, x);
    n = 1;
    while (resp_vld == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single_latency", n, 6);
    chk("single_resp_vld", resp_vld, 4'b0001 << r);
    chk("single_resp_y", resp_y, y);
    cyc();
  endtask

  typedef struct {
    int          req;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] x;
    logic [3:0]  rdy;
    logic        chk_resp;
    logic [3:0]  rv;
    logic [31:0] ry;
  } step_t;

  vec_t       vecs [9];
  step_t      steps [12];
  logic [3:0] rr_exp [7];

  initial begin
    vecs[0] = '{0, 32'd9, 32'd3};
    vecs[1] = '{1, 32'd0, 32'd0};
    vecs[2] = '{2, 32'd1, 32'd1};
    vecs[3] = '{3, 32'd15, 32'd3};
    vecs[4] = '{0, 32'd16, 32'd4};
    vecs[5] = '{1, 32'hFFFF_FFFF, 32'd65535};
    vecs[6] = '{2, 32'h4000_0000, 32'd32768};
    vecs[7] = '{3, 32'd99, 32'd9};
    vecs[8] = '{0, 32'd100, 32'd10};

`ifdef ISQRT_ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
`endif

    steps[0]  = '{4'b0010, 32'd4,  4'b0010, 1'b0, 4'b0000, 32'd0};
    steps[1]  = '{4'b0100, 32'd9,  4'b0100, 1'b0, 4'b0000, 32'd0};
    steps[2]  = '{4'b0000, 32'd0,  4'b0000, 1'b0, 4'b0000, 32'd0};
    steps[3]  = '{4'b0000, 32'd0,  4'b0000, 1'b0, 4'b0000, 32'd0};
    steps[4]  = '{4'b0000, 32'd0,  4'b0000, 1'b0, 4'b0000, 32'd0};
    steps[5]  = '{4'b1000, 32'd64, 4'b1000, 1'b0, 4'b0000, 32'd0};
    steps[6]  = '{4'b0000, 32'd0,  4'b0000, 1'b1, 4'b0010, 32'd2};
    steps[7]  = '{4'b0000, 32'd0,  4'b0000, 1'b1, 4'b0100, 32'd3};
    steps[8]  = '{4'b0000, 32'd0,  4'b0000, 1'b1, 4'b0000, 32'd3};
    steps[9]  = '{4'b0000, 32'd0,  4'b0000, 1'b1, 4'b0000, 32'd3};
    steps[10] = '{4'b0000, 32'd0,  4'b0000, 1'b1, 4'b0000, 32'd3};
    steps[11] = '{4'b0000, 32'd0,  4'b0000, 1'b1, 4'b1000, 32'd8};

    // Reset
    rst = 1'b1;
    req_vld = '0;
    req_x = '0;
    inj_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    cyc();
    rst = 1'b0;

    // Single ops from the vector table
    for (int i = 0; i < 9; i++) single(vecs[i].req, vecs[i].x, vecs[i].y);
    idle(4);

    // Round-robin order and credit limit, from a fresh reset
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    req_x = {32'd49, 32'd36, 32'd25, 32'd16};
    req_vld = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("rr_grant", req_rdy, rr_exp[c]);
      if (c == 5) chk("full_pop_same_cycle", sqrt_y_vld, 1);
      cyc();
    end
    idle(15);

    // Accept and pop in the same cycle at inflight 2
    for (int c = 0; c < 12; c++) begin
      req_vld = steps[c].vld;
      req_x = {4{steps[c].x}};
      @(negedge clk);
      chk("sim_rdy", req_rdy, steps[c].rdy);
      if (c == 5) chk("sim_pop", sqrt_y_vld, 1);
      if (steps[c].chk_resp) begin
        chk("sim_resp_vld", resp_vld, steps[c].rv);
        chk("sim_resp_y", resp_y, steps[c].ry);
      end
      cyc();
    end
    idle(4);

    // Protocol error: result strobe with nothing outstanding
    inj_vld = 1'b1;
    cyc();
    inj_vld = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
    chk("err_no_resp", resp_vld, 0);
    chk("err_resp_y_hold", resp_y, 8);
    cyc();
    idle(3);
    @(negedge clk);
    chk("err_sticky", err, 1);
    cyc();

    // Reset with three ops outstanding
    req_x = {32'd100, 32'd81, 32'd64, 32'd49};
    req_vld = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_accept", |req_rdy, 1);
      cyc();
    end
    req_vld = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("mid_reset");
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no_stale_resp", resp_vld, 0);
      cyc();
    end
    single(2, 32'd0, 32'd0);
    idle(4);

    // Random traffic
    for (int c = 0; c < 1000; c++) begin
      req_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++)
        req_x[i*32 +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2000));
      cyc();
    end
    idle(20);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("rand_queue_empty", exp_q[i].size(), 0);
    chk("rand_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
